branch_decode_pipe: RTL and testbench
=====================================

BRANCH_DECODE_PIPE -- requirements
Module: branch_decode_pipe

Interface
REQ-001: The block SHALL expose parameter IMM_W, default 20, giving immediate output width; legal range 20..32.
REQ-002: The block SHALL expose parameter PC_W, default 32, giving the width of the carried PC tag.
REQ-003: The block SHALL expose parameter CNT_W, default 8, giving the width of the illegal-instruction counter.
REQ-004: The block SHALL have one clock, with reset synchronous and active-low; the ports are as follows:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  discard all buffered and incoming entries.
- in_valid  in  1  producer offers an instruction.
- in_ready  out  1  block can accept an instruction.
- in_inst  in  32  RV32 instruction word.
- in_pc  in  PC_W  PC tag carried unchanged.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes the head entry.
- out_pc  out  PC_W  PC tag of the head entry.
- out_is_nop, out_is_jmp, out_is_imm_type, out_zero_ext, out_is_sys, out_illegal  out  1 each  decoded flags.
- out_op  out  2  compare/jump op.
- out_rs1, out_rs2, out_rd  out  5 each  register indices.
- out_imm  out  IMM_W  sign-extended immediate.
- illegal_cnt  out  CNT_W  saturating count of accepted illegal instructions.

Function
REQ-005: Decode SHALL occur at acceptance; each buffer entry stores decoded fields plus the PC, never the raw word.
REQ-006: For opcode 1100011 (branch), the decode SHALL set rs1=inst[19:15], rs2=inst[24:20], rd=0, and imm=sext({inst[31],inst[7],inst[30:25],inst[11:8]}) in half-word units. It SHALL set zero_ext=1 for funct3 6/7. It SHALL set op=00 for funct3 0, 01 for 1, 10 for 4/6, and 11 for 5/7.
REQ-007: A branch with funct3 2 or 3 SHALL decode as illegal.
REQ-008: For opcode 1101111 (JAL), the decode SHALL set rd=inst[11:7], imm=sext({inst[31],inst[19:12],inst[20],inst[30:21]}), is_jmp=1, and op=00.
REQ-009: For opcode 1100111 (JALR), the decode SHALL set rs1=inst[19:15], rd=inst[11:7], imm=sext(inst[31:20]), is_jmp=1, and is_imm_type=1.
REQ-010: For opcode 1110011 (ECALL/EBREAK), the decode SHALL set imm=sext(inst[31:20]), is_jmp=1, is_sys=1, op=01, and rs1=rs2=rd=0.
REQ-011: An all-zero instruction SHALL decode as is_nop=1 with all other fields 0.
REQ-012: Any other instruction SHALL decode as illegal: out_illegal=1 and all other fields 0. No simulation error or halt SHALL occur.
REQ-013: Storage SHALL be a 2-entry in-order FIFO; in_ready = (count != 2).
REQ-014: A push SHALL occur on in_valid && in_ready; a pop SHALL occur on out_valid && out_ready.
REQ-015: Latency: an instruction pushed into the empty FIFO at edge N SHALL be presented (out_valid=1) after edge N; there is no combinational in-to-out path.
REQ-016: Push and pop in the same cycle with count 1 SHALL leave count at 1 and preserve order.
REQ-017: At count 2, no push SHALL occur even if out_ready=1 in that cycle.
REQ-018: While out_valid=0, all out_* data fields SHALL read 0.
REQ-019: flush=1 SHALL set count to 0 at the edge, drop any same-cycle push, and ignore out_ready; illegal_cnt SHALL not increment for a dropped push.
REQ-020: illegal_cnt SHALL increment by 1 per non-flushed push decoding illegal, and SHALL saturate at 2^CNT_W-1.
REQ-021: Read/write pointers SHALL wrap modulo 2.

Reset
REQ-022: While rst_n=0 at an edge, count, pointers, and illegal_cnt SHALL go to 0, and storage SHALL be cleared.
REQ-023: While rst_n=0, pushes and pops SHALL be ignored.
REQ-024: After reset, out_valid=0 and in_ready=1.
REQ-025: Reset SHALL take priority over flush and handshakes.

Verification
REQ-026: Push 0x00208463 (beq x1,x2,8) with pc 0x100 -> next cycle out_valid=1, op=00, rs1=1, rs2=2, imm=4, out_pc=0x100, zero_ext=0.
REQ-027: Push 0xFFDFF0EF (jal x1,-4) -> rd=1, is_jmp=1, imm=all-ones-minus-1 (-2 sign-extended), is_imm_type=0.
REQ-028: Push 0x0020A463 (funct3=2) -> out_illegal=1, all other fields 0, illegal_cnt=1; with CNT_W=2, 5 illegal pushes -> illegal_cnt=3.
REQ-029: With out_ready=0, offer A,B,C back-to-back -> A,B accepted, in_ready=0 on C; raise out_ready -> A then B then C delivered in order.
REQ-030: With count=2 and in_valid=1, assert flush for one cycle -> next cycle out_valid=0, in_ready=1, illegal_cnt unchanged.
REQ-031: Drop rst_n with count=2 and illegal_cnt=5 -> next edge out_valid=0, illegal_cnt=0, and all out_* fields 0.

Source files
------------

// File: rtl/branch_decode_pipe.sv
// Branch/jump decoder with a 2-entry in-order output FIFO.
// Instructions are decoded when accepted. The FIFO stores decoded fields and the PC tag.
module branch_decode_pipe #(
    parameter int IMM_W = 20,
    parameter int PC_W  = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [PC_W-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  out_pc,
    output logic             out_is_nop,
    output logic             out_is_jmp,
    output logic             out_is_imm_type,
    output logic             out_zero_ext,
    output logic             out_is_sys,
    output logic             out_illegal,
    output logic [1:0]       out_op,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic [IMM_W-1:0] out_imm,
    output logic [CNT_W-1:0] illegal_cnt
);

    typedef struct packed {
        logic             is_nop;
        logic             is_jmp;
        logic             is_imm_type;
        logic             zero_ext;
        logic             is_sys;
        logic             illegal;
        logic [1:0]       op;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
        logic [IMM_W-1:0] imm;
        logic [PC_W-1:0]  pc;
    } entry_t;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    entry_t          mem [2];
    entry_t          dec;
    entry_t          head;
    logic [1:0]      count;
    logic            wr_ptr;
    logic            rd_ptr;
    logic            push;
    logic            pop;

    logic [2:0]          funct3;
    logic signed [11:0]  b_imm;
    logic signed [11:0]  i_imm;
    logic signed [19:0]  j_imm;

    assign funct3 = in_inst[14:12];
    assign b_imm  = {in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8]};
    assign i_imm  = in_inst[31:20];
    assign j_imm  = {in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21]};

    // NOTE: dec gets a full default before the case so no path leaves a field unassigned (no latch).
    always_comb begin
        dec    = '0;
        dec.pc = in_pc;
        unique case (in_inst[6:0])
            OPC_BRANCH: begin
                if (funct3 == 3'd2 || funct3 == 3'd3) begin
                    dec.illegal = 1'b1;
                end else begin
                    dec.rs1      = in_inst[19:15];
                    dec.rs2      = in_inst[24:20];
                    dec.imm      = IMM_W'(b_imm);
                    dec.zero_ext = funct3[2] & funct3[1];
                    // funct3 {0,1,4,5,6,7} -> op {00,01,10,11,10,11}
                    dec.op       = funct3[2] ? {1'b1, funct3[0]} : {1'b0, funct3[0]};
                end
            end
            OPC_JAL: begin
                dec.rd     = in_inst[11:7];
                dec.imm    = IMM_W'(j_imm);
                dec.is_jmp = 1'b1;
            end
            OPC_JALR: begin
                dec.rs1         = in_inst[19:15];
                dec.rd          = in_inst[11:7];
                dec.imm         = IMM_W'(i_imm);
                dec.is_jmp      = 1'b1;
                dec.is_imm_type = 1'b1;
            end
            OPC_SYSTEM: begin
                dec.imm    = IMM_W'(i_imm);
                dec.is_jmp = 1'b1;
                dec.is_sys = 1'b1;
                dec.op     = 2'b01;
            end
            default: begin
                if (in_inst == 32'h0) dec.is_nop  = 1'b1;
                else                  dec.illegal = 1'b1;
            end
        endcase
    end

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count       <= 2'd0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            illegal_cnt <= '0;
            // NOTE: storage is cleared on reset; it is only two entries and outputs must read clean.
            mem[0]      <= '0;
            mem[1]      <= '0;
        end else if (flush) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= dec;
                wr_ptr      <= ~wr_ptr;
                if (dec.illegal && illegal_cnt != CNT_MAX) illegal_cnt <= illegal_cnt + 1'b1;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    // Data fields read zero whenever nothing is presented.
    assign head = out_valid ? mem[rd_ptr] : '0;

    assign out_pc          = head.pc;
    assign out_is_nop      = head.is_nop;
    assign out_is_jmp      = head.is_jmp;
    assign out_is_imm_type = head.is_imm_type;
    assign out_zero_ext    = head.zero_ext;
    assign out_is_sys      = head.is_sys;
    assign out_illegal     = head.illegal;
    assign out_op          = head.op;
    assign out_rs1         = head.rs1;
    assign out_rs2         = head.rs2;
    assign out_rd          = head.rd;
    assign out_imm         = head.imm;

endmodule

// File: tb/tb_branch_decode_pipe.sv
// Directed self-checking bench for branch_decode_pipe.
// A second instance with CNT_W=2 shares the stimulus to check counter saturation.
module tb_branch_decode_pipe;

    localparam int IMM_W = 20;
    localparam int PC_W  = 32;

    logic clk = 1'b0;
    logic rst_n, flush, in_valid, out_ready;
    logic [31:0]     in_inst;
    logic [PC_W-1:0] in_pc;

    logic             in_ready, out_valid;
    logic [PC_W-1:0]  out_pc;
    logic             out_is_nop, out_is_jmp, out_is_imm_type, out_zero_ext, out_is_sys, out_illegal;
    logic [1:0]       out_op;
    logic [4:0]       out_rs1, out_rs2, out_rd;
    logic [IMM_W-1:0] out_imm;
    logic [7:0]       illegal_cnt;

    logic             in_ready_b, out_valid_b;
    logic [PC_W-1:0]  out_pc_b;
    logic             is_nop_b, is_jmp_b, is_imm_type_b, zero_ext_b, is_sys_b, illegal_b;
    logic [1:0]       op_b;
    logic [4:0]       rs1_b, rs2_b, rd_b;
    logic [IMM_W-1:0] imm_b;
    logic [1:0]       illegal_cnt_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    branch_decode_pipe #(.IMM_W(IMM_W), .PC_W(PC_W), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_is_nop(out_is_nop), .out_is_jmp(out_is_jmp),
        .out_is_imm_type(out_is_imm_type), .out_zero_ext(out_zero_ext), .out_is_sys(out_is_sys),
        .out_illegal(out_illegal), .out_op(out_op), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_rd(out_rd), .out_imm(out_imm), .illegal_cnt(illegal_cnt)
    );

    branch_decode_pipe #(.IMM_W(IMM_W), .PC_W(PC_W), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_pc(out_pc_b), .out_is_nop(is_nop_b), .out_is_jmp(is_jmp_b),
        .out_is_imm_type(is_imm_type_b), .out_zero_ext(zero_ext_b), .out_is_sys(is_sys_b),
        .out_illegal(illegal_b), .out_op(op_b), .out_rs1(rs1_b), .out_rs2(rs2_b),
        .out_rd(rd_b), .out_imm(imm_b), .illegal_cnt(illegal_cnt_b)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] inst, input logic [PC_W-1:0] pc);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
        step();
        in_valid = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_pc = '0;
        step();
        step();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_illegal_cnt", illegal_cnt, 0);
        rst_n = 1'b1;

        // beq x1,x2,8 -> half-word offset 4
        push_one(32'h0020_8463, 32'h100);
        check("beq_valid", out_valid, 1);
        check("beq_op", out_op, 2'b00);
        check("beq_rs1", out_rs1, 1);
        check("beq_rs2", out_rs2, 2);
        check("beq_rd", out_rd, 0);
        check("beq_imm", out_imm, 20'h00004);
        check("beq_pc", out_pc, 32'h100);
        check("beq_zext", out_zero_ext, 0);
        check("beq_jmp", out_is_jmp, 0);
        pop_one();
        check("empty_valid", out_valid, 0);
        check("empty_rs1_zero", out_rs1, 0);
        check("empty_pc_zero", out_pc, 0);

        // jal x1,-4 -> imm -2
        push_one(32'hFFDF_F0EF, 32'h104);
        check("jal_rd", out_rd, 1);
        check("jal_jmp", out_is_jmp, 1);
        check("jal_imm", out_imm, 20'hFFFFE);
        check("jal_immtype", out_is_imm_type, 0);
        check("jal_op", out_op, 2'b00);
        pop_one();

        // branch funct3=2 is illegal
        push_one(32'h0020_A463, 32'h108);
        check("ill_flag", out_illegal, 1);
        check("ill_rs1", out_rs1, 0);
        check("ill_rs2", out_rs2, 0);
        check("ill_imm", out_imm, 0);
        check("ill_op", out_op, 0);
        check("ill_cnt", illegal_cnt, 1);
        check("ill_cnt_sat", illegal_cnt_b, 1);
        pop_one();

        // jalr x5,12(x6)
        push_one(32'h00C3_02E7, 32'h10C);
        check("jalr_rs1", out_rs1, 6);
        check("jalr_rd", out_rd, 5);
        check("jalr_imm", out_imm, 20'h0000C);
        check("jalr_immtype", out_is_imm_type, 1);
        check("jalr_jmp", out_is_jmp, 1);
        pop_one();

        // bgeu x3,x4 with half-word offset -2
        push_one(32'hFE41_FEE3, 32'h110);
        check("bgeu_op", out_op, 2'b11);
        check("bgeu_zext", out_zero_ext, 1);
        check("bgeu_imm", out_imm, 20'hFFFFE);
        check("bgeu_rs1", out_rs1, 3);
        check("bgeu_rs2", out_rs2, 4);
        pop_one();

        // ebreak
        push_one(32'h0010_0073, 32'h114);
        check("ebrk_sys", out_is_sys, 1);
        check("ebrk_jmp", out_is_jmp, 1);
        check("ebrk_op", out_op, 2'b01);
        check("ebrk_imm", out_imm, 1);
        check("ebrk_rd", out_rd, 0);
        pop_one();

        // all-zero word is a nop
        push_one(32'h0, 32'h118);
        check("nop_flag", out_is_nop, 1);
        check("nop_illegal", out_illegal, 0);
        check("nop_cnt", illegal_cnt, 1);
        pop_one();

        // unsupported opcodes
        push_one(32'h0000_0013, 32'h11C);
        check("addi_illegal", out_illegal, 1);
        pop_one();
        push_one(32'hFFFF_FFFF, 32'h120);
        check("ones_illegal", out_illegal, 1);
        check("ones_cnt", illegal_cnt, 3);
        check("ones_cnt_sat", illegal_cnt_b, 3);
        pop_one();

        // backpressure: A, B accepted, C held off until space frees
        in_valid = 1'b1; in_inst = 32'h0020_B463; in_pc = 32'hA00;
        step();
        check("bp_ready_after_a", in_ready, 1);
        in_inst = 32'h0020_8463; in_pc = 32'hB00;
        step();
        check("bp_ready_full", in_ready, 0);
        in_inst = 32'h0000_0013; in_pc = 32'hC00;
        step();
        check("bp_ready_on_c", in_ready, 0);
        check("bp_head_a", out_pc, 32'hA00);
        check("bp_cnt_before_c", illegal_cnt, 4);
        out_ready = 1'b1;
        step();
        check("bp_head_b", out_pc, 32'hB00);
        check("bp_ready_after_pop", in_ready, 1);
        step();
        in_valid = 1'b0;
        check("bp_head_c", out_pc, 32'hC00);
        check("bp_valid_c", out_valid, 1);
        check("bp_ready_cnt1", in_ready, 1);
        check("bp_cnt_after_c", illegal_cnt, 5);
        check("bp_cnt_sat_hold", illegal_cnt_b, 3);
        step();
        out_ready = 1'b0;
        check("bp_drained", out_valid, 0);

        // flush with a full FIFO and an offered illegal instruction
        push_one(32'h0, 32'hD00);
        push_one(32'hFFDF_F0EF, 32'hD04);
        check("fl_full", in_ready, 0);
        in_valid = 1'b1; in_inst = 32'h0020_A463; flush = 1'b1;
        step();
        check("fl_valid", out_valid, 0);
        check("fl_ready", in_ready, 1);
        check("fl_cnt", illegal_cnt, 5);
        // flush from empty drops the push
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_drop_valid", out_valid, 0);
        check("fl_drop_cnt", illegal_cnt, 5);

        // reset with a full FIFO and nonzero counter, push offered during reset
        push_one(32'hFFDF_F0EF, 32'hE00);
        push_one(32'h0020_8463, 32'hE04);
        check("rs_full", in_ready, 0);
        rst_n = 1'b0; in_valid = 1'b1; in_inst = 32'h0020_A463; out_ready = 1'b1;
        step();
        check("rs_valid", out_valid, 0);
        check("rs_cnt", illegal_cnt, 0);
        check("rs_imm", out_imm, 0);
        check("rs_pc", out_pc, 0);
        check("rs_rd", out_rd, 0);
        check("rs_ready", in_ready, 1);
        step();
        check("rs_hold_valid", out_valid, 0);
        check("rs_hold_cnt", illegal_cnt, 0);
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        step();
        check("post_rs_valid", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
